adc_capture_dma: RTL
====================

Name: adc_capture_dma

Overview:
- Parametrised successor to the single-channel AD9254 capture path.
- Accepts a validated ADC sample stream and applies optional decimation and a level-crossing trigger.
- Buffers samples in a small FIFO and writes a programmable number of them to sample memory over the master write port.
- Supports single-shot and continuous (ring) capture; controlled and monitored over a 32-bit register slave port.

Parameters:
DATA_W, 14, ADC sample width
OUT_W, 16, memory word width (>= DATA_W)
ADDR_W, 17, master address width (<= 24)
FIFO_DEPTH, 16, sample FIFO entries (power of 2)
SIGN_EXT, 0, 1 = sign-extend samples to OUT_W, 0 = zero-extend; also selects signed/unsigned trigger compare

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
slave_chip_select_n  in  1  register access select, active-low
slave_address  in  2  register index
slave_read  in  1  read strobe
slave_readdata  out  32  read data, registered
slave_write  in  1  write strobe
slave_writedata  in  32  write data
master_chip_select_n  out  1  memory write select, active-low
master_addr  out  ADDR_W  sample word address
master_write  out  1  write strobe
master_writedata  out  OUT_W  extended sample
master_waitrequest_n  in  1  1 = beat accepted this cycle
adc_data  in  DATA_W  ADC sample
adc_valid  in  1  sample qualifier
adc_or  in  1  ADC out-of-range flag
irq  out  1  one-cycle pulse on capture completion

Behaviour:
- Reset values (async, immediate): master_chip_select_n=1, master_write=0, master_addr=0, master_writedata=0, slave_readdata=0, irq=0; all registers 0; FIFO empty; state IDLE.
- Registers, accessed with slave_chip_select_n=0:
  - Addr 0, CTRL (R/W): [31] start, write-only, self-clearing; [30] continuous; [29] trigger enable; [28] trigger edge (0 rising, 1 falling); [ADDR_W-1:0] CNT = samples-1.
  - Addr 1, CFG (R/W): [31:16] DEC = decimation-1; [15:0] trigger level, low DATA_W bits used.
  - Addr 2, STATUS (RO): [31] busy; [30] done; [29] overflow; [28] armed; [27] range (sticky adc_or on a captured sample); [ADDR_W-1:0] next write address.
  - Addr 2 write: bit[0]=1 aborts.
  - Addr 3 reads 0.
- Read latency: slave_readdata valid the cycle after the read cycle; held until the next read.
- Start is accepted only in IDLE; start while busy is ignored.
- On start: done, overflow and range are cleared; write address = 0; decimation counter = 0.
- FSM:
  - IDLE -> ARM on start with trigger enabled; IDLE -> CAPTURE on start without trigger.
  - ARM: a trigger is a valid sample whose previous valid sample was < level and current >= level (rising), or previous >= level and current < level (falling). The triggering sample is the first candidate for capture. ARM -> CAPTURE on trigger.
  - CAPTURE: a valid sample is captured when the decimation counter = 0; the counter wraps at DEC.
    - Single-shot: after CNT+1 samples are pushed -> DRAIN.
    - Continuous: the address wraps from CNT to 0 and capture never ends.
  - DRAIN -> IDLE when the FIFO is empty and no beat is outstanding. Set done and pulse irq for 1 cycle, unless the drain was entered by abort.
  - Abort: ARM -> IDLE immediately; CAPTURE -> DRAIN with no done and no irq.
- FIFO full on capture: the sample is dropped, overflow is set (sticky), and the address does not advance.
- Master port:
  - Asserts select and write while the FIFO is non-empty.
  - addr and data stay stable until the cycle master_waitrequest_n=1; the FIFO pops on that cycle.
  - The next beat may follow back-to-back.
- A push and a pop in the same cycle with FIFO full is legal; nothing is dropped.
- The trigger-level compare is signed when SIGN_EXT=1, otherwise unsigned.

Test Plan:
- CTRL write 0x800001FF, CFG=0, adc_valid=1, waitrequest_n=1 -> 512 writes at addr 0..511 with the sample stream; done=1, one irq pulse, STATUS addr = 0x200.
- CFG DEC=3, CNT=7, ramp input 0,1,2,... -> writedata 0,4,8,...,28 at addr 0..7.
- Trigger enabled rising, level 0x2000, 128-entry sine -> first written sample is the first crossing sample >= 0x2000 after a sample < 0x2000; armed=1 before the crossing.
- waitrequest_n held 0 for 40 cycles during capture with FIFO_DEPTH=16 -> overflow=1, exactly 16 samples retained, no write while stalled, addr/data stable.
- Continuous mode, CNT=3 -> addresses 0,1,2,3,0,1,...; abort -> master drains, busy=0, done=0, no irq.
- Reset asserted mid-CAPTURE -> outputs return to reset values immediately; next start behaves as the first test.

Source files
------------

// File: rtl/adc_capture_dma.sv
// ADC capture path: validated sample stream -> decimation / level trigger -> sample FIFO
// -> memory write master, with single-shot or ring capture and a 32-bit register port.
module adc_capture_dma #(
    parameter int DATA_W     = 14,
    parameter int OUT_W      = 16,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16,
    parameter int SIGN_EXT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slave_chip_select_n,
    input  logic [1:0]        slave_address,
    input  logic              slave_read,
    output logic [31:0]       slave_readdata,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic              master_chip_select_n,
    output logic [ADDR_W-1:0] master_addr,
    output logic              master_write,
    output logic [OUT_W-1:0]  master_writedata,
    input  logic              master_waitrequest_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              adc_or,
    output logic              irq
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + OUT_W;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

    state_t state_reg, state_next;

    logic              continuous_reg;
    logic              trig_en_reg;
    logic              trig_edge_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [15:0]       dec_reg;
    logic [15:0]       level_reg;
    logic              done_reg;
    logic              overflow_reg;
    logic              range_reg;
    logic              aborted_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [15:0]       dec_cnt_reg;
    logic              prev_below_reg;
    logic              prev_seen_reg;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;

    logic              reg_wr;
    logic              reg_rd;
    logic              start;
    logic              abort;
    logic              below_cur;
    logic              trig_hit;
    logic              capturing;
    logic              take;
    logic              push;
    logic              drop;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              last_push;
    logic              drain_done;
    logic [OUT_W-1:0]  sample_ext;
    logic [31:0]       rd_mux;

    assign reg_wr = !slave_chip_select_n && slave_write;
    assign reg_rd = !slave_chip_select_n && slave_read;
    assign start  = reg_wr && (slave_address == 2'd0) && slave_writedata[31] && (state_reg == IDLE);
    assign abort  = reg_wr && (slave_address == 2'd2) && slave_writedata[0];

    // Sample extension and trigger compare share the signedness choice.
    generate
        if (SIGN_EXT != 0) begin : g_signed
            assign sample_ext = OUT_W'($signed(adc_data));
            assign below_cur  = $signed(adc_data) < $signed(level_reg[DATA_W-1:0]);
        end else begin : g_unsigned
            assign sample_ext = OUT_W'(adc_data);
            assign below_cur  = adc_data < level_reg[DATA_W-1:0];
        end
    endgenerate

    assign trig_hit = (state_reg == ARM) && adc_valid && prev_seen_reg &&
                      (trig_edge_reg ? (!prev_below_reg && below_cur)
                                     : (prev_below_reg && !below_cur));

    assign capturing  = adc_valid && ((state_reg == CAPTURE) || trig_hit);
    assign take       = capturing && (dec_cnt_reg == 16'd0);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign pop        = !fifo_empty && master_waitrequest_n;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push       = take && (!fifo_full || pop);
    assign drop       = take && !push;
    assign last_push  = push && !continuous_reg && (wr_addr_reg == cnt_reg);
    assign drain_done = (state_reg == DRAIN) && fifo_empty;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = slave_writedata[29] ? ARM : CAPTURE;
            ARM:     if (abort) state_next = IDLE;
                     else if (last_push) state_next = DRAIN;
                     else if (trig_hit) state_next = CAPTURE;
            CAPTURE: if (abort || last_push) state_next = DRAIN;
            DRAIN:   if (fifo_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            irq            <= 1'b0;
            continuous_reg <= 1'b0;
            trig_en_reg    <= 1'b0;
            trig_edge_reg  <= 1'b0;
            cnt_reg        <= '0;
            dec_reg        <= '0;
            level_reg      <= '0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            range_reg      <= 1'b0;
            aborted_reg    <= 1'b0;
            wr_addr_reg    <= '0;
            dec_cnt_reg    <= '0;
            prev_below_reg <= 1'b0;
            prev_seen_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            irq       <= drain_done && !aborted_reg;
            if (start) begin
                done_reg     <= 1'b0;
                overflow_reg <= 1'b0;
                range_reg    <= 1'b0;
                aborted_reg  <= 1'b0;
                wr_addr_reg  <= '0;
                dec_cnt_reg  <= '0;
            end else begin
                if (drain_done && !aborted_reg)
                    done_reg <= 1'b1;
                if (abort && (state_reg == CAPTURE))
                    aborted_reg <= 1'b1;
                if (drop)
                    overflow_reg <= 1'b1;
                if (push && adc_or)
                    range_reg <= 1'b1;
                if (push)
                    wr_addr_reg <= (continuous_reg && (wr_addr_reg == cnt_reg)) ? '0
                                                                               : wr_addr_reg + 1'b1;
                if (capturing)
                    dec_cnt_reg <= (dec_cnt_reg == dec_reg) ? '0 : dec_cnt_reg + 1'b1;
            end
            // Trigger history follows every valid sample, armed or not.
            if (adc_valid) begin
                prev_below_reg <= below_cur;
                prev_seen_reg  <= 1'b1;
            end
            // CTRL fields are frozen while busy so a running capture keeps a consistent length.
            if (reg_wr && (slave_address == 2'd0) && (state_reg == IDLE)) begin
                continuous_reg <= slave_writedata[30];
                trig_en_reg    <= slave_writedata[29];
                trig_edge_reg  <= slave_writedata[28];
                cnt_reg        <= slave_writedata[ADDR_W-1:0];
            end
            if (reg_wr && (slave_address == 2'd1)) begin
                dec_reg   <= slave_writedata[31:16];
                level_reg <= slave_writedata[15:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (slave_address)
            2'd0: begin
                rd_mux[30]           = continuous_reg;
                rd_mux[29]           = trig_en_reg;
                rd_mux[28]           = trig_edge_reg;
                rd_mux[ADDR_W-1:0]   = cnt_reg;
            end
            2'd1: rd_mux = {dec_reg, level_reg};
            2'd2: begin
                rd_mux[31]           = (state_reg != IDLE);
                rd_mux[30]           = done_reg;
                rd_mux[29]           = overflow_reg;
                rd_mux[28]           = (state_reg == ARM);
                rd_mux[27]           = range_reg;
                rd_mux[ADDR_W-1:0]   = wr_addr_reg;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            slave_readdata <= '0;
        else if (reg_rd)
            slave_readdata <= rd_mux;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {wr_addr_reg, sample_ext};
    end

    // Head entry is read asynchronously so address and data accompany the select in the same cycle.
    assign master_chip_select_n = fifo_empty;
    assign master_write         = !fifo_empty;
    assign {master_addr, master_writedata} = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];

endmodule
